// File: rtl/bp_stream_mmio_host.sv
// Serializes each io_cmd as an opcode/addr/data packet of 32-bit flits, gathers read data, returns one io_resp.
// Flit 0 leaves one cycle after accept; stream_v_o/io_resp_v_o hold stable data until their handshake completes.
module bp_stream_mmio_host #(
  parameter int paddr_width_p       = 40,
  parameter int dword_width_p       = 64,
  parameter int cce_block_width_p   = 128,
  parameter int payload_width_p     = 8,
  parameter int msg_type_width_p    = 4,
  parameter int msg_size_width_p    = 3,
  parameter int stream_data_width_p = 32,
  parameter int nbf_opcode_width_p  = 8,
  parameter int nbf_addr_width_p    = paddr_width_p,
  parameter int nbf_data_width_p    = dword_width_p,
  localparam int hdr_width_lp = payload_width_p + msg_size_width_p + paddr_width_p + msg_type_width_p,
  localparam int cce_mem_msg_width_lp = hdr_width_lp + cce_block_width_p,
  localparam int pkt_width_lp = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p,
  localparam int nbf_num_flits_lp = (pkt_width_lp + stream_data_width_p - 1) / stream_data_width_p,
  localparam int rd_num_flits_lp = (nbf_data_width_p + stream_data_width_p - 1) / stream_data_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_ready_o,
  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_yumi_i,
  output logic [stream_data_width_p-1:0]  stream_data_o,
  output logic                            stream_v_o,
  input  logic                            stream_ready_i,
  input  logic [stream_data_width_p-1:0]  stream_data_i,
  input  logic                            stream_v_i,
  output logic                            stream_ready_o
);

  localparam int cnt_width_lp = (nbf_num_flits_lp > 1) ? $clog2(nbf_num_flits_lp) : 1;
  localparam int pkt_flat_width_lp = nbf_num_flits_lp * stream_data_width_p;
  localparam int rd_flat_width_lp = rd_num_flits_lp * stream_data_width_p;
  localparam logic [cnt_width_lp-1:0] send_last_lp = cnt_width_lp'(nbf_num_flits_lp - 1);
  localparam logic [cnt_width_lp-1:0] recv_last_lp = cnt_width_lp'(rd_num_flits_lp - 1);
  localparam logic [msg_type_width_p-1:0] e_cce_mem_wr    = msg_type_width_p'(1);
  localparam logic [msg_type_width_p-1:0] e_cce_mem_uc_wr = msg_type_width_p'(3);

  typedef struct packed {
    logic [payload_width_p-1:0]  payload;
    logic [msg_size_width_p-1:0] size;
    logic [paddr_width_p-1:0]    addr;
    logic [msg_type_width_p-1:0] msg_type;
  } hdr_t;

  typedef enum logic [1:0] {IDLE, SEND, RECV, RESP} state_e;

  state_e                          state_r;
  logic [cnt_width_lp-1:0]         cnt_r;
  hdr_t                            hdr_r;
  logic [nbf_data_width_p-1:0]     wdata_r;
  logic [rd_flat_width_lp-1:0]     rdata_r;

  logic                            is_wr;
  logic [1:0]                      size_code;
  logic [nbf_opcode_width_p-1:0]   opcode;
  logic [pkt_flat_width_lp-1:0]    pkt_flat;
  logic [cce_block_width_p-1:0]    resp_data;

  assign is_wr = (hdr_r.msg_type == e_cce_mem_wr) || (hdr_r.msg_type == e_cce_mem_uc_wr);

  // Anything wider than a dword is clamped to the 8-byte opcode; only the low dword travels.
  assign size_code = (hdr_r.size > msg_size_width_p'(3)) ? 2'd3 : hdr_r.size[1:0];

  always_comb begin
    opcode = '0;
    opcode[1:0] = size_code;
    opcode[4] = ~is_wr;
  end

  always_comb begin
    pkt_flat = '0;
    pkt_flat[pkt_width_lp-1:0] = {opcode, nbf_addr_width_p'(hdr_r.addr), wdata_r};
  end

  assign resp_data = is_wr ? '0 : cce_block_width_p'(rdata_r[nbf_data_width_p-1:0]);

  assign io_cmd_ready_o = reset_n_i && (state_r == IDLE);
  assign stream_v_o     = reset_n_i && (state_r == SEND);
  assign stream_ready_o = reset_n_i && (state_r == RECV);
  assign io_resp_v_o    = reset_n_i && (state_r == RESP);
  assign stream_data_o  = pkt_flat[cnt_r*stream_data_width_p +: stream_data_width_p];
  assign io_resp_o      = {resp_data, hdr_r};

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      hdr_r   <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (io_cmd_v_i) begin
            hdr_r   <= io_cmd_i[hdr_width_lp-1:0];
            wdata_r <= io_cmd_i[hdr_width_lp +: nbf_data_width_p];
            rdata_r <= '0;
            cnt_r   <= '0;
            state_r <= SEND;
          end
        end
        SEND: begin
          if (stream_ready_i) begin
            if (cnt_r == send_last_lp) begin
              cnt_r   <= '0;
              state_r <= is_wr ? RESP : RECV;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
        end
        RECV: begin
          if (stream_v_i) begin
            rdata_r[cnt_r*stream_data_width_p +: stream_data_width_p] <= stream_data_i;
            if (cnt_r == recv_last_lp) begin
              cnt_r   <= '0;
              state_r <= RESP;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
        end
        RESP: begin
          if (io_resp_yumi_i) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  generate
    if (cce_block_width_p > nbf_data_width_p) begin : g_cmd_hi
      logic cmd_unused;
      assign cmd_unused = ^io_cmd_i[cce_mem_msg_width_lp-1:hdr_width_lp+nbf_data_width_p];
    end
  endgenerate

endmodule
